cache_trace_mon: RTL and testbench
==================================

Name: cache_trace_mon

Overview:
- Synthesizable, parametrised monitor for the N-way cache controller. Replaces simulation-only hierarchical probes with an in-design block.
- Counts per-way hits, misses and dirty evictions.
- Captures the request stream into a DEPTH-entry trace buffer, either one-shot or with a masked-address trigger and post-trigger window.
- Buffer is read back through an index port. Sits beside the cache FSM and is fed from the controller's request/hit/evict signals.

Parameters:
- WAYS, 4, cache associativity; width of the one-hot hit vector.
- ADDR_W, 32, request address width.
- DATA_W, 32, request data word width.
- DEPTH, 16, trace entries; must be a power of 2, at least 2.
- CNT_W, 32, event counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_en  in  1  enable counting and capture.
- cfg_clr  in  1  synchronous clear of counters, pointers, error flag and state.
- cfg_trig_en  in  1  1: triggered capture; 0: one-shot fill.
- cfg_trig_addr  in  ADDR_W  trigger address.
- cfg_trig_mask  in  ADDR_W  trigger compare mask (1 = compare bit).
- cfg_post_cnt  in  log2(DEPTH)+1  entries captured after the trigger entry.
- mon_valid  in  1  cache accepted a request this cycle.
- mon_wr  in  1  request is a write.
- mon_addr  in  ADDR_W  request address.
- mon_data  in  DATA_W  write data, or read data returned.
- mon_way_hit  in  WAYS  one-hot hit way; all zero means miss.
- mon_evict  in  1  one-cycle pulse, dirty line written back.
- rd_idx  in  log2(DEPTH)  read index, 0 = oldest entry.
- rd_addr  out  ADDR_W  captured address.
- rd_data  out  DATA_W  captured data.
- rd_info  out  2+log2(WAYS)  {wr, hit, way_idx}.
- cap_state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.
- cap_count  out  log2(DEPTH)+1  valid entries, saturating at DEPTH.
- hit_cnt  out  WAYS*CNT_W  per-way hit counters; way0 in the LSBs.
- miss_cnt  out  CNT_W  miss counter.
- evict_cnt  out  CNT_W  eviction counter.
- err_multihit  out  1  sticky flag: mon_way_hit was multi-hot.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs, counters, pointers and the error flag are 0.
  - cap_state is IDLE.
  - Trace RAM contents are not reset.
- cfg_clr (synchronous) restores the reset values except RAM contents. cfg_clr has priority over every other event in the same cycle.
- Counters:
  - Update only when cfg_en=1.
  - Each counter saturates at all-ones and never wraps.
  - mon_valid with one-hot mon_way_hit increments hit_cnt[way].
  - mon_valid with zero mon_way_hit increments miss_cnt.
  - mon_valid with multi-hot mon_way_hit sets err_multihit and increments no counter.
  - mon_evict increments evict_cnt, independent of mon_valid.
  - Counter outputs update one cycle after the event.
- Capture FSM:
  - IDLE to ARMED when cfg_en=1.
  - In ARMED and POST, each mon_valid with cfg_en=1 writes {addr, data, wr, hit, way_idx} at wr_ptr.
  - wr_ptr wraps from DEPTH-1 to 0. cap_count increments and saturates at DEPTH.
  - ARMED with cfg_trig_en=0: go to DONE on the write that makes cap_count equal DEPTH. No wrap occurs.
  - ARMED with cfg_trig_en=1: the buffer runs circularly.
    - Trigger condition: mon_valid and ((mon_addr ^ cfg_trig_addr) & cfg_trig_mask) == 0.
    - The trigger entry is captured.
    - If cfg_post_cnt=0, go to DONE. Otherwise load post_rem=cfg_post_cnt and go to POST.
  - POST: each captured write decrements post_rem. Go to DONE on the write that makes it 0.
  - cfg_post_cnt values greater than DEPTH-1 are clamped to DEPTH-1, so the trigger entry is never overwritten.
  - DONE: no writes. State holds until cfg_clr.
  - cfg_en=0 in ARMED or POST freezes the state, pointers and counters. Capture resumes when cfg_en returns to 1.
  - cfg_en=0 in IDLE: stay in IDLE.
- Readout:
  - Physical index = (oldest + rd_idx) mod DEPTH, where oldest = 0 if cap_count < DEPTH, else wr_ptr.
  - Outputs are registered, with 1-cycle latency from rd_idx.
  - If rd_idx >= cap_count, rd_addr, rd_data and rd_info return 0.
  - Reading during capture is allowed. A read and a write to the same physical entry in the same cycle returns the old contents.

Decomposition:
- Shared package cache_mon_pkg holds:
  - cap_state encodings (IDLE/ARMED/POST/DONE).
  - rd_info field offsets (WR_BIT, HIT_BIT, WAY_LSB).
  - The trace-entry width function of ADDR_W, DATA_W and WAYS.
- One sub-module, mon_trace_ram: DEPTH x entry, one write port, one registered read port, read-old-data on collision.
- Counters, FSM and the one-hot-to-index encoder stay in the top module.

Test Plan:
1. Reset, then cfg_en=1. Apply 3 hits on way2, 2 misses and 1 mon_evict. Required: hit_cnt[2]=3, other ways 0, miss_cnt=2, evict_cnt=1, err_multihit=0.
2. cfg_trig_en=0, DEPTH=16. Issue 20 requests at addresses 0x100+4k. Required: cap_state=DONE after the 16th request, cap_count=16, rd_idx=0 returns 0x100 and rd_idx=15 returns 0x13C.
3. cfg_trig_en=1, trig_addr=0x2000, mask=0xFFFFFFF0, post_cnt=3. Issue 30 requests, the 21st at 0x2008. Required: DONE after the 24th, cap_count=16, rd_idx=12 returns addr 0x2008.
4. mon_way_hit=4'b0110 with mon_valid. Required: err_multihit=1 and stays 1, no counter changes. cfg_clr then sets it to 0.
5. Assert rst_n low during POST. Required: cap_state=IDLE and all counters 0 immediately. With cap_count=0, rd_idx=0 returns 0 on all read outputs.
6. Bring hit_cnt[0] to all-ones using CNT_W=4 and 17 hits. Required: hit_cnt[0]=4'hF, no wrap.

Source files
------------

// File: rtl/cache_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module : cache_mon_pkg
// Brief  : Shared types, field offsets and sizing helpers for cache_trace_mon.
// Rev    : 1.0
// ============================================================================
package cache_mon_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE  = 2'd0,
        CAP_ARMED = 2'd1,
        CAP_POST  = 2'd2,
        CAP_DONE  = 2'd3
    } cap_state_e;

    // rd_info is {wr, hit, way_idx}; the way index sits at bit 0
    localparam int WAY_LSB = 0;

    function automatic int way_idx_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int hit_bit(input int ways);
        return WAY_LSB + way_idx_w(ways);
    endfunction

    function automatic int wr_bit(input int ways);
        return hit_bit(ways) + 1;
    endfunction

    function automatic int entry_w(input int addr_w, input int data_w, input int ways);
        return addr_w + data_w + 2 + way_idx_w(ways);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mon_trace_ram.sv
`default_nettype none
// ============================================================================
// Module : mon_trace_ram
// Brief  : DEPTH x WIDTH trace store, one write port, registered read port.
// Rev    : 1.0
// ============================================================================
module mon_trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 68
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Non-blocking read of r_mem yields the pre-write contents on a collision
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cache_trace_mon.sv
`default_nettype none
// ============================================================================
// Module : cache_trace_mon
// Brief  : Per-way hit/miss/evict counters plus a triggerable request trace.
// Rev    : 1.0
// ============================================================================
module cache_trace_mon
    import cache_mon_pkg::*;
#(
    parameter int WAYS   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_en,
    input  logic                          cfg_clr,
    input  logic                          cfg_trig_en,
    input  logic [ADDR_W-1:0]             cfg_trig_addr,
    input  logic [ADDR_W-1:0]             cfg_trig_mask,
    input  logic [$clog2(DEPTH):0]        cfg_post_cnt,
    input  logic                          mon_valid,
    input  logic                          mon_wr,
    input  logic [ADDR_W-1:0]             mon_addr,
    input  logic [DATA_W-1:0]             mon_data,
    input  logic [WAYS-1:0]               mon_way_hit,
    input  logic                          mon_evict,
    input  logic [$clog2(DEPTH)-1:0]      rd_idx,
    output logic [ADDR_W-1:0]             rd_addr,
    output logic [DATA_W-1:0]             rd_data,
    output logic [way_idx_w(WAYS)+1:0]    rd_info,
    output logic [1:0]                    cap_state,
    output logic [$clog2(DEPTH):0]        cap_count,
    output logic [WAYS*CNT_W-1:0]         hit_cnt,
    output logic [CNT_W-1:0]              miss_cnt,
    output logic [CNT_W-1:0]              evict_cnt,
    output logic                          err_multihit
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int WAY_W   = way_idx_w(WAYS);
    localparam int WR_BIT  = wr_bit(WAYS);
    localparam int HIT_BIT = hit_bit(WAYS);
    localparam int ENTRY_W = entry_w(ADDR_W, DATA_W, WAYS);
    localparam logic [IDX_W:0] C_FULL = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] C_LAST = (IDX_W+1)'(DEPTH - 1);

    cap_state_e          r_state;
    logic [IDX_W-1:0]    r_wr_ptr;
    logic [IDX_W:0]      r_count;
    logic [IDX_W:0]      r_post_rem;
    logic [CNT_W-1:0]    r_miss_cnt;
    logic [CNT_W-1:0]    r_evict_cnt;
    logic                r_err_multihit;
    logic                r_rd_valid;

    logic [WAY_W-1:0]    w_way_idx;
    logic                w_hit_any;
    logic                w_onehot;
    logic                w_multi;
    logic                w_trig;
    logic                w_cap_we;
    logic [IDX_W:0]      w_post_clamp;
    logic [IDX_W-1:0]    w_oldest;
    logic [IDX_W-1:0]    w_rd_phys;
    logic [ENTRY_W-1:0]  w_wr_entry;
    logic [ENTRY_W-1:0]  w_rd_entry;

    always_comb begin
        w_way_idx = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (mon_way_hit[i]) begin
                w_way_idx = WAY_W'(i);
            end
        end
    end

    assign w_hit_any    = |mon_way_hit;
    assign w_onehot     = w_hit_any && ((mon_way_hit & (mon_way_hit - WAYS'(1))) == '0);
    assign w_multi      = w_hit_any && !w_onehot;
    assign w_trig       = ((mon_addr ^ cfg_trig_addr) & cfg_trig_mask) == '0;
    assign w_cap_we     = cfg_en && mon_valid && ((r_state == CAP_ARMED) || (r_state == CAP_POST));
    // Capping the window at DEPTH-1 keeps the trigger entry from being overwritten
    assign w_post_clamp = (cfg_post_cnt > C_LAST) ? C_LAST : cfg_post_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CAP_IDLE;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_post_rem <= '0;
        end else if (cfg_clr) begin
            r_state    <= CAP_IDLE;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_post_rem <= '0;
        end else begin
            if (w_cap_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_count != C_FULL) begin
                    r_count <= r_count + 1'b1;
                end
            end
            case (r_state)
                CAP_IDLE: begin
                    if (cfg_en) begin
                        r_state <= CAP_ARMED;
                    end
                end
                CAP_ARMED: begin
                    if (w_cap_we) begin
                        if (!cfg_trig_en) begin
                            if (r_count >= C_LAST) begin
                                r_state <= CAP_DONE;
                            end
                        end else if (w_trig) begin
                            if (w_post_clamp == '0) begin
                                r_state <= CAP_DONE;
                            end else begin
                                r_post_rem <= w_post_clamp;
                                r_state    <= CAP_POST;
                            end
                        end
                    end
                end
                CAP_POST: begin
                    if (w_cap_we) begin
                        r_post_rem <= r_post_rem - 1'b1;
                        if (r_post_rem <= (IDX_W+1)'(1)) begin
                            r_state <= CAP_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_hit
            logic [CNT_W-1:0] r_hit;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hit <= '0;
                end else if (cfg_clr) begin
                    r_hit <= '0;
                end else if (cfg_en && mon_valid && w_onehot && mon_way_hit[g] && (r_hit != '1)) begin
                    r_hit <= r_hit + 1'b1;
                end
            end
            assign hit_cnt[g*CNT_W +: CNT_W] = r_hit;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miss_cnt     <= '0;
            r_evict_cnt    <= '0;
            r_err_multihit <= 1'b0;
        end else if (cfg_clr) begin
            r_miss_cnt     <= '0;
            r_evict_cnt    <= '0;
            r_err_multihit <= 1'b0;
        end else if (cfg_en) begin
            if (mon_valid && !w_hit_any && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
            if (mon_evict && (r_evict_cnt != '1)) begin
                r_evict_cnt <= r_evict_cnt + 1'b1;
            end
            if (mon_valid && w_multi) begin
                r_err_multihit <= 1'b1;
            end
        end
    end

    // Once the buffer has wrapped, the next write slot holds the oldest entry
    assign w_oldest  = (r_count == C_FULL) ? r_wr_ptr : '0;
    assign w_rd_phys = w_oldest + rd_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
        end else if (cfg_clr) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= ({1'b0, rd_idx} < r_count);
        end
    end

    assign w_wr_entry = {mon_addr, mon_data, mon_wr, w_onehot, w_way_idx};

    mon_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_cap_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (w_rd_phys),
        .o_rdata (w_rd_entry)
    );

    assign rd_addr      = r_rd_valid ? w_rd_entry[ENTRY_W-1 -: ADDR_W] : '0;
    assign rd_data      = r_rd_valid ? w_rd_entry[WR_BIT+1 +: DATA_W] : '0;
    assign rd_info      = r_rd_valid ? w_rd_entry[WR_BIT:WAY_LSB] : '0;
    assign cap_state    = r_state;
    assign cap_count    = r_count;
    assign miss_cnt     = r_miss_cnt;
    assign evict_cnt    = r_evict_cnt;
    assign err_multihit = r_err_multihit;

    // HIT_BIT documents the entry layout; referenced here to keep it tied to WR_BIT
    if (HIT_BIT + 1 != WR_BIT) begin : g_layout_bad
        $error("rd_info layout inconsistent");
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_trace_mon.sv
`default_nettype none
// ============================================================================
// Module : tb_cache_trace_mon
// Brief  : Directed self-checking bench for cache_trace_mon (CNT_W=4).
// Rev    : 1.0
// ============================================================================
module tb_cache_trace_mon;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_en, cfg_clr, cfg_trig_en;
    logic [31:0] cfg_trig_addr, cfg_trig_mask;
    logic [4:0]  cfg_post_cnt;
    logic        mon_valid, mon_wr, mon_evict;
    logic [31:0] mon_addr, mon_data;
    logic [3:0]  mon_way_hit;
    logic [3:0]  rd_idx;
    logic [31:0] rd_addr, rd_data;
    logic [3:0]  rd_info;
    logic [1:0]  cap_state;
    logic [4:0]  cap_count;
    logic [15:0] hit_cnt;
    logic [3:0]  miss_cnt, evict_cnt;
    logic        err_multihit;

    int checks = 0;
    int errors = 0;

    cache_trace_mon #(
        .WAYS(4), .ADDR_W(32), .DATA_W(32), .DEPTH(16), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_clr(cfg_clr),
        .cfg_trig_en(cfg_trig_en), .cfg_trig_addr(cfg_trig_addr),
        .cfg_trig_mask(cfg_trig_mask), .cfg_post_cnt(cfg_post_cnt),
        .mon_valid(mon_valid), .mon_wr(mon_wr), .mon_addr(mon_addr),
        .mon_data(mon_data), .mon_way_hit(mon_way_hit), .mon_evict(mon_evict),
        .rd_idx(rd_idx), .rd_addr(rd_addr), .rd_data(rd_data), .rd_info(rd_info),
        .cap_state(cap_state), .cap_count(cap_count), .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt), .evict_cnt(evict_cnt), .err_multihit(err_multihit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] h);
        mon_valid = 1'b1; mon_wr = wr; mon_addr = a; mon_data = d; mon_way_hit = h;
        tick();
        mon_valid = 1'b0; mon_wr = 1'b0; mon_addr = '0; mon_data = '0; mon_way_hit = '0;
    endtask

    task automatic do_clr();
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] a;
        rst_n = 1'b0; cfg_en = 1'b0; cfg_clr = 1'b0; cfg_trig_en = 1'b0;
        cfg_trig_addr = '0; cfg_trig_mask = '0; cfg_post_cnt = '0;
        mon_valid = 1'b0; mon_wr = 1'b0; mon_addr = '0; mon_data = '0;
        mon_way_hit = '0; mon_evict = 1'b0; rd_idx = '0;
        repeat (2) tick();

        check("rst_state", cap_state, 2'd0);
        check("rst_count", cap_count, 5'd0);
        check("rst_hit", hit_cnt, 16'h0);
        check("rst_miss", miss_cnt, 4'h0);
        check("rst_evict", evict_cnt, 4'h0);
        check("rst_err", err_multihit, 1'b0);
        check("rst_rd_addr", rd_addr, 32'h0);
        rst_n = 1'b1;
        tick();

        // Counters: 3 hits on way2, 2 misses, 1 eviction
        cfg_en = 1'b1;
        tick();
        check("t1_armed", cap_state, 2'd1);
        for (int k = 0; k < 3; k++) req(1'b0, 32'h40 + 32'(k), 32'h0, 4'b0100);
        for (int k = 0; k < 2; k++) req(1'b1, 32'h80 + 32'(k), 32'h0, 4'b0000);
        mon_evict = 1'b1;
        tick();
        mon_evict = 1'b0;
        check("t1_hit_cnt", hit_cnt, 16'h0300);
        check("t1_miss", miss_cnt, 4'h2);
        check("t1_evict", evict_cnt, 4'h1);
        check("t1_err", err_multihit, 1'b0);
        check("t1_count", cap_count, 5'd5);

        // One-shot fill
        cfg_trig_en = 1'b0;
        do_clr();
        check("t2_clr_count", cap_count, 5'd0);
        check("t2_clr_miss", miss_cnt, 4'h0);
        check("t2_armed", cap_state, 2'd1);
        for (int k = 0; k < 20; k++) begin
            req(k[0], 32'h100 + 32'(4 * k), 32'(k), 4'(1 << (k % 4)));
            if (k == 14) check("t2_armed15", cap_state, 2'd1);
            if (k == 15) begin
                check("t2_done16", cap_state, 2'd3);
                check("t2_count16", cap_count, 5'd16);
            end
        end
        check("t2_done_end", cap_state, 2'd3);
        check("t2_count_end", cap_count, 5'd16);
        rd_idx = 4'd0;
        tick();
        check("t2_rd0_addr", rd_addr, 32'h100);
        check("t2_rd0_data", rd_data, 32'h0);
        check("t2_rd0_info", rd_info, 4'b0100);
        rd_idx = 4'd15;
        tick();
        check("t2_rd15_addr", rd_addr, 32'h13C);
        check("t2_rd15_data", rd_data, 32'hF);
        check("t2_rd15_info", rd_info, 4'hF);

        // Triggered capture with 3-entry post window
        cfg_trig_en = 1'b1; cfg_trig_addr = 32'h2000;
        cfg_trig_mask = 32'hFFFF_FFF0; cfg_post_cnt = 5'd3;
        do_clr();
        for (int k = 0; k < 30; k++) begin
            a = (k == 20) ? 32'h2008 : 32'h3000 + 32'(4 * k);
            req(1'b0, a, 32'(k), 4'b0000);
            if (k == 19) begin
                check("t3_armed20", cap_state, 2'd1);
                check("t3_count20", cap_count, 5'd16);
            end
            if (k == 20) check("t3_post21", cap_state, 2'd2);
            if (k == 22) check("t3_post23", cap_state, 2'd2);
            if (k == 23) check("t3_done24", cap_state, 2'd3);
        end
        check("t3_done_end", cap_state, 2'd3);
        check("t3_count", cap_count, 5'd16);
        rd_idx = 4'd12;
        tick();
        check("t3_rd12_addr", rd_addr, 32'h2008);
        check("t3_rd12_data", rd_data, 32'h14);
        check("t3_rd12_info", rd_info, 4'h0);
        rd_idx = 4'd0;
        tick();
        check("t3_rd0_addr", rd_addr, 32'h3020);
        rd_idx = 4'd15;
        tick();
        check("t3_rd15_addr", rd_addr, 32'h305C);

        // Multi-hot hit vector
        do_clr();
        req(1'b0, 32'h5000, 32'h0, 4'b0110);
        check("t4_err", err_multihit, 1'b1);
        check("t4_hit", hit_cnt, 16'h0);
        check("t4_miss", miss_cnt, 4'h0);
        tick();
        check("t4_err_sticky", err_multihit, 1'b1);
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        check("t4_err_clr", err_multihit, 1'b0);

        // cfg_en low: IDLE holds, ARMED freezes
        cfg_en = 1'b0;
        tick();
        check("t4_idle_hold", cap_state, 2'd0);
        cfg_en = 1'b1;
        tick();
        cfg_en = 1'b0;
        req(1'b0, 32'h5000, 32'h0, 4'b0000);
        check("t4_frz_miss", miss_cnt, 4'h0);
        check("t4_frz_count", cap_count, 5'd0);
        check("t4_frz_state", cap_state, 2'd1);
        cfg_en = 1'b1;

        // Asynchronous reset during POST
        do_clr();
        req(1'b0, 32'h3000, 32'h1, 4'b0000);
        req(1'b0, 32'h2004, 32'h2, 4'b0000);
        check("t5_post", cap_state, 2'd2);
        check("t5_miss_pre", miss_cnt, 4'h2);
        rd_idx = 4'd0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_state", cap_state, 2'd0);
        check("t5_count", cap_count, 5'd0);
        check("t5_miss", miss_cnt, 4'h0);
        check("t5_hit", hit_cnt, 16'h0);
        check("t5_evict", evict_cnt, 4'h0);
        check("t5_rd_addr", rd_addr, 32'h0);
        check("t5_rd_data", rd_data, 32'h0);
        check("t5_rd_info", rd_info, 4'h0);
        rst_n = 1'b1;
        tick();

        // Hit counter saturation
        cfg_trig_en = 1'b0;
        tick();
        for (int k = 0; k < 15; k++) req(1'b0, 32'h600, 32'h0, 4'b0001);
        check("t6_hit15", hit_cnt, 16'h000F);
        for (int k = 0; k < 2; k++) req(1'b0, 32'h600, 32'h0, 4'b0001);
        check("t6_hit17", hit_cnt, 16'h000F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
